// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the parametrised UART blocks (transmitter today,
// receiver later).
//   uart_state_t  : frame state encoding (S_IDLE .. S_BREAK)
//   PARITY_*      : parity mode constants used by the PARITY_MODE parameter
//   calc_parity() : parity bit for a data word, zero-extended to 9 bits
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } uart_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    localparam int MAX_DATA_BITS = 9;

    // Unused upper bits must be zero so they do not disturb the reduction.
    function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] word,
                                         input int mode);
        logic p;
        p = ^word;
        return (mode == PARITY_ODD) ? ~p : p;
    endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// -----------------------------------------------------------------------------
// uart_tx_param_if
// Valid/ready word handshake between a byte-stream source and uart_tx_param.
//   i_VALID : source presents a word
//   i_DATA  : word to transmit (DATA_BITS wide)
//   o_READY : transmitter can accept a word
// Modports: master = source side, slave = transmitter side.
// -----------------------------------------------------------------------------
interface uart_tx_param_if #(
    parameter int DATA_BITS = 8
);
    logic                 i_VALID;
    logic [DATA_BITS-1:0] i_DATA;
    logic                 o_READY;

    modport master (
        output i_VALID,
        output i_DATA,
        input  o_READY
    );

    modport slave (
        input  i_VALID,
        input  i_DATA,
        output o_READY
    );
endinterface

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and wraps.
//   i_CLK   : clock
//   i_RESET : synchronous, active-high reset (counter to 0)
//   i_CLEAR : hold the counter at 0 (takes priority over i_EN)
//   i_EN    : count
//   o_TICK  : high during the terminal-count cycle of an enabled period
// -----------------------------------------------------------------------------
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic i_CLK,
    input  logic i_RESET,
    input  logic i_CLEAR,
    input  logic i_EN,
    output logic o_TICK
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_baud_gen: CLKS_PER_BIT must be >= 2");
    end

    logic [CW-1:0] cnt_q, cnt_d;
    logic          term;

    assign term   = (cnt_q == TERM);
    assign o_TICK = i_EN && !i_CLEAR && term;

    always_comb begin
        cnt_d = cnt_q;
        if (i_CLEAR) begin
            cnt_d = '0;
        end else if (i_EN) begin
            cnt_d = term ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/uart_tx_param.sv
// -----------------------------------------------------------------------------
// uart_tx_param
// Parametrised UART transmitter, LSB first:
//   start, DATA_BITS data, optional parity, STOP_BITS stop bits.
// Parameters: CLKS_PER_BIT (>=2), DATA_BITS (5..9), PARITY_MODE (0 none,
//   1 odd, 2 even), STOP_BITS (1 or 2).
// Ports:
//   i_CLK, i_RESET : clock, synchronous active-high reset
//   s_if (slave)   : i_VALID / i_DATA / o_READY word handshake
//   i_BREAK        : line-break request (only with UART_TX_BREAK_EN)
//   o_TX           : registered serial line, idle high
//   o_TX_BUSY      : high while a frame (or break) is in progress
//   o_DONE         : one-cycle pulse when a frame completes
// Build option: define UART_TX_BREAK_EN to add i_BREAK and the BREAK state.
// -----------------------------------------------------------------------------
module uart_tx_param #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic           i_CLK,
    input  logic           i_RESET,
    uart_tx_param_if.slave s_if,
`ifdef UART_TX_BREAK_EN
    input  logic           i_BREAK,
`endif
    output logic           o_TX,
    output logic           o_TX_BUSY,
    output logic           o_DONE
);
    import uart_pkg::*;

    localparam int BCW = 4;
    localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_BITS - 1);
    localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_tx_param: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS) begin : g_bad_db
        $error("uart_tx_param: DATA_BITS must be 5..9");
    end
    if (PARITY_MODE < PARITY_NONE || PARITY_MODE > PARITY_EVEN) begin : g_bad_pm
        $error("uart_tx_param: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_sb
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end

    uart_state_t          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
    logic                 baud_clear, baud_en, baud_tick;
    logic                 brk_in;

`ifdef UART_TX_BREAK_EN
    assign brk_in = i_BREAK;
`else
    assign brk_in = 1'b0;
`endif

    // The counter is held at 0 while idle and while the break is asserted,
    // so the first period after either always lasts a full CLKS_PER_BIT.
    assign baud_en    = (state_q != S_IDLE);
    assign baud_clear = (state_q == S_IDLE) || ((state_q == S_BREAK) && brk_in);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .i_CLK  (i_CLK),
        .i_RESET(i_RESET),
        .i_CLEAR(baud_clear),
        .i_EN   (baud_en),
        .o_TICK (baud_tick)
    );

    // Break has priority, so a pending word is not handshaken while it is up.
    assign s_if.o_READY = (state_q == S_IDLE) && !brk_in;
    assign o_TX_BUSY    = (state_q != S_IDLE);
    assign o_TX         = tx_q;
    assign o_DONE       = done_q;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        bit_cnt_d = bit_cnt_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (brk_in) begin
                    state_d = S_BREAK;
                end else if (s_if.i_VALID) begin
                    state_d   = S_START;
                    shift_d   = s_if.i_DATA;
                    parity_d  = calc_parity(MAX_DATA_BITS'(s_if.i_DATA), PARITY_MODE);
                    bit_cnt_d = '0;
                end
            end
            S_START: begin
                if (baud_tick) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_tick) begin
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY_MODE != PARITY_NONE) ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (baud_tick) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                // bit_cnt_q is reused to count stop bits.
                if (baud_tick) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        bit_cnt_d = '0;
                        state_d   = S_IDLE;
                        done_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end
            end
`ifdef UART_TX_BREAK_EN
            S_BREAK: begin
                // Ticks only after i_BREAK drops: one bit period of mark.
                if (baud_tick) begin
                    state_d = S_IDLE;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Line level follows the next state so o_TX changes on the same edge
        // as the state register.
        tx_d = 1'b1;
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = parity_d;
`ifdef UART_TX_BREAK_EN
            S_BREAK:  tx_d = ~brk_in;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
        end
    end
endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter, successor to the fixed 8N1 transmitter.
- Configurable baud divider, data width, parity mode and stop-bit count.
- Valid/ready input handshake and a frame-done pulse.
- Sits between a byte-stream source (FIFO or CPU register) and the serial pin; frames are sent LSB first.

Parameters:
CLKS_PER_BIT, 16, i_CLK cycles per serial bit; must be >= 2, else elaboration error.
DATA_BITS, 8, data bits per frame; legal range 5..9, else elaboration error.
PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even; value 3 is an elaboration error.
STOP_BITS, 1, stop bits per frame; 1 or 2.

Ports:
i_CLK  in  1  clock
i_RESET  in  1  synchronous, active-high reset
i_VALID  in  1  source presents a word on i_DATA
i_DATA  in  DATA_BITS  word to transmit
o_READY  out  1  block can accept a word; 1 only in IDLE
o_TX  out  1  serial line, registered, idle high
o_TX_BUSY  out  1  high from the start bit until the end of the last stop bit
o_DONE  out  1  one-cycle pulse when a frame completes

Behaviour:
- Reset is synchronous and active-high on i_RESET, clocked by i_CLK. Values after a reset edge: state IDLE, o_TX=1, o_READY=1, o_TX_BUSY=0, o_DONE=0, baud and bit counters=0.
- Reset mid-frame aborts the frame. o_TX returns high on the next edge and no o_DONE pulse is issued.
- States: IDLE -> START -> DATA -> PARITY (only when PARITY_MODE != 0) -> STOP -> IDLE.
- Accept: in the cycle where i_VALID && o_READY, i_DATA is latched into the shift register and the state moves to START. Later changes on i_DATA have no effect.
- Latency: acceptance at edge N gives o_TX=0 and o_TX_BUSY=1 from edge N+1.
- Baud counter:
  - Runs 0..CLKS_PER_BIT-1 in every non-IDLE state and clears on each bit transition.
  - Every bit lasts exactly CLKS_PER_BIT cycles.
- DATA state:
  - The shift register shifts right once per bit; o_TX = shift[0].
  - The bit counter runs 0..DATA_BITS-1 and leaves DATA when the count is DATA_BITS-1 and the baud counter is terminal.
- Parity bit:
  - Odd = ~^data; even = ^data, computed on the latched word.
  - The parity bit lasts one bit period.
- STOP: o_TX=1 for STOP_BITS bit periods.
- Frame end: on the edge after the final stop-bit cycle, the state returns to IDLE with o_READY=1, o_TX_BUSY=0 and o_DONE=1 for exactly one cycle.
- Back-to-back frames:
  - i_VALID held high is accepted in the o_DONE cycle.
  - The minimum inter-frame gap is therefore exactly one extra cycle of mark.
- Frame length in cycles: CLKS_PER_BIT*(1+DATA_BITS+(PARITY_MODE!=0)+STOP_BITS).
- i_VALID outside IDLE is ignored; there is no queuing.

Optional Feature:
UART_TX_BREAK_EN
- Defined:
  - Adds input i_BREAK (1 bit) and a BREAK state.
  - In IDLE, i_BREAK=1 takes priority over i_VALID and enters BREAK on the next edge.
  - In BREAK: o_TX=0, o_READY=0, o_TX_BUSY=1, for as long as i_BREAK stays high.
  - On deassertion, o_TX=1 is held for one full bit period (CLKS_PER_BIT cycles), then IDLE. No o_DONE pulse.
  - i_BREAK raised during a frame is ignored until IDLE is reached.
- Undefined: no i_BREAK port and no BREAK state; behaviour is exactly as above.

Decomposition:
- Package uart_pkg:
  - State encoding localparams: S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK.
  - Parity constants: PARITY_NONE=0, PARITY_ODD=1, PARITY_EVEN=2.
  - Shared by the future uart_rx_param.
- Sub-module uart_baud_gen:
  - Parametrised by CLKS_PER_BIT.
  - Inputs: i_CLK, i_RESET, i_CLEAR, i_EN.
  - Output: o_TICK, high on the terminal count.

Test Plan:
1. CLKS_PER_BIT=4, DATA_BITS=8, PARITY_MODE=2, STOP_BITS=1; send 0x8A -> o_TX bit sequence 0,0,1,0,1,0,0,0,1,1(parity),1(stop), each bit exactly 4 cycles. Frame length 44 cycles, o_DONE on cycle 45 after accept.
2. Same configuration with PARITY_MODE=1, send 0xFF -> parity bit 1. With PARITY_MODE=0 -> no parity bit and a 40-cycle frame.
3. i_VALID held high with 0x55 then 0xA3 -> second start bit begins exactly one cycle after the o_DONE cycle. Two o_DONE pulses; o_READY is low for the whole of each frame.
4. DATA_BITS=5, STOP_BITS=2, send 0x1F -> 5 data bits of 1, stop high for 8 cycles. Bits above bit 4 of i_DATA are not transmitted.
5. Assert i_RESET while o_TX is in data bit 3 -> next edge o_TX=1, o_TX_BUSY=0, o_READY=1, no o_DONE. The next accepted word transmits correctly.
6. UART_TX_BREAK_EN: i_BREAK high for 20 cycles in IDLE with i_VALID=1 -> o_TX low for 20 cycles, then high for 4 cycles, then the pending word is accepted.
